pwd_checker: RTL
================

PWD_CHECKER -- requirements
Module: pwd_checker

Interface
REQ-001 Parameter DIGIT_W, default 4: width of one entered digit in bits.
REQ-002 Parameter PWD_LEN, default 4: number of digits in the password, ≥1.
REQ-003 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout, ≥1.
REQ-004 Parameter LOCK_CYCLES, default 16: lockout duration in clk cycles, ≥1.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 key_digit  input  DIGIT_W  entered digit value, qualified by key_valid.
REQ-008 key_valid  input  1  one-cycle strobe; one digit accepted per high cycle.
REQ-009 key_clear  input  1  abandons the current entry.
REQ-010 pwd_in  input  PWD_LEN*DIGIT_W  stored password; digit 0 occupies the MSBs; must be held stable during an entry.
REQ-011 unlock  output  1  one-cycle pulse when the password is correct.
REQ-012 fail  output  1  one-cycle pulse when the password is wrong.
REQ-013 locked  output  1  high for the whole lockout period.
REQ-014 digit_cnt  output  clog2(PWD_LEN+1)  number of digits accepted in the current entry.
REQ-015 fail_cnt  output  clog2(MAX_FAIL+1)  consecutive failures so far.

Function
REQ-016 The FSM SHALL have three states: ENTRY, CHECK and LOCK.
REQ-017 ENTRY, key_valid=1, key_clear=0: compare key_digit with pwd_in digit [digit_cnt]; on mismatch set an internal mismatch flag; increment digit_cnt.
REQ-018 When the PWD_LEN-th digit is accepted, the FSM SHALL go to CHECK on the next edge, with digit_cnt=PWD_LEN.
REQ-019 CHECK is one cycle; the result pulse is registered and asserts on the cycle after CHECK, i.e. 2 cycles after the last key_valid.
REQ-020 CHECK with mismatch=0: unlock=1, fail_cnt cleared to 0, go to ENTRY.
REQ-021 CHECK with mismatch=1 and fail_cnt+1<MAX_FAIL: fail=1, fail_cnt increments, go to ENTRY.
REQ-022 CHECK with mismatch=1 and fail_cnt+1=MAX_FAIL: fail=1, fail_cnt=MAX_FAIL, go to LOCK, locked=1 in the same cycle as fail.
REQ-023 Leaving CHECK SHALL clear digit_cnt and the mismatch flag.
REQ-024 LOCK: locked=1 for exactly LOCK_CYCLES cycles, using an internal down-counter.
REQ-025 LOCK expiry: locked=0, fail_cnt cleared to 0, go to ENTRY.
REQ-026 key_valid and key_clear SHALL be ignored in CHECK and LOCK; they have no effect on any state.
REQ-027 key_clear in ENTRY: digit_cnt and the mismatch flag clear on the next edge; fail_cnt is unchanged; no pulse.
REQ-028 key_clear and key_valid in the same cycle: clear wins and the digit is discarded.
REQ-029 unlock and fail SHALL never both be high; each is high for exactly one cycle per attempt.
REQ-030 All outputs SHALL be registered.
REQ-031 digit_cnt SHALL never exceed PWD_LEN; fail_cnt SHALL never exceed MAX_FAIL.

Reset
REQ-032 rst_n=0 SHALL immediately force: state ENTRY, unlock=0, fail=0, locked=0, digit_cnt=0, fail_cnt=0, mismatch flag 0, lock counter 0.
REQ-033 Reset asserted mid-entry or mid-lock SHALL abort the operation; no pulse is emitted after release.
REQ-034 The first key_valid SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (defaults; pwd_in=16'h1234)
REQ-035 Correct entry: keys 1,2,3,4 on consecutive cycles -> digit_cnt reaches 4; unlock=1 for one cycle, 2 cycles after key 4; fail_cnt=0.
REQ-036 Wrong entry: keys 1,2,3,5 -> fail=1 for one cycle; fail_cnt=1; digit_cnt=0.
REQ-037 Lockout: three wrong entries -> the third fail pulse coincides with locked rising; locked=1 for 16 cycles; keys during lock change nothing; afterwards fail_cnt=0, and 1,2,3,4 -> unlock.
REQ-038 Clear: keys 1,9, then key_clear, then 1,2,3,4 -> no fail pulse; unlock=1; fail_cnt unchanged.
REQ-039 Simultaneous clear and key: key_clear=1 with key_valid=1 on the second digit -> digit_cnt=0 next cycle.
REQ-040 Reset: rst_n low during LOCK after 5 cycles -> locked=0 and fail_cnt=0 asynchronously; a correct entry after release -> unlock.

Source files
------------

// File: rtl/pwd_checker_if.sv
// Bundle of keypad, password and status signals for pwd_checker.
// master : the keypad/controller side (drives key_*, pwd_in; observes status).
// slave  : the pwd_checker side (consumes key_*, pwd_in; drives status).
// Ports carried: key_digit, key_valid, key_clear, pwd_in (to checker);
//                unlock, fail, locked, digit_cnt, fail_cnt (from checker).
interface pwd_checker_if #(
  parameter int DIGIT_W  = 4,
  parameter int PWD_LEN  = 4,
  parameter int MAX_FAIL = 3
);
  localparam int CNT_W  = $clog2(PWD_LEN + 1);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);

  logic [DIGIT_W-1:0]         key_digit;
  logic                       key_valid;
  logic                       key_clear;
  logic [PWD_LEN*DIGIT_W-1:0] pwd_in;
  logic                       unlock;
  logic                       fail;
  logic                       locked;
  logic [CNT_W-1:0]           digit_cnt;
  logic [FCNT_W-1:0]          fail_cnt;

  modport master (
    output key_digit, key_valid, key_clear, pwd_in,
    input  unlock, fail, locked, digit_cnt, fail_cnt
  );

  modport slave (
    input  key_digit, key_valid, key_clear, pwd_in,
    output unlock, fail, locked, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/pwd_checker.sv
// Keypad password checker with consecutive-failure lockout.
// Digits are compared one at a time against pwd_in (digit 0 in the MSBs);
// a sticky mismatch flag records any wrong digit. After PWD_LEN digits the
// FSM spends one CHECK cycle, then emits a registered unlock or fail pulse.
// MAX_FAIL consecutive failures enter LOCK for LOCK_CYCLES cycles.
// Ports: clk, rst_n (async, active-low) and the pwd_checker_if slave modport.
module pwd_checker #(
  parameter int DIGIT_W     = 4,
  parameter int PWD_LEN     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic            clk,
  input logic            rst_n,
  pwd_checker_if.slave   bus
);
  localparam int CNT_W  = $clog2(PWD_LEN + 1);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);
  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                unlock_q, unlock_d;
  logic                fail_q, fail_d;
  logic                locked_q, locked_d;
  logic                mismatch_q, mismatch_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;

  logic [DIGIT_W-1:0]  exp_digit_s;
  logic                accept_s;
  logic                accept_last_s;
  logic                last_fail_s;

  // Select the expected digit for the current position (digit 0 = MSBs).
  always_comb begin
    exp_digit_s = {DIGIT_W{1'b0}};
    for (int i = 0; i < PWD_LEN; i++) begin
      if (digit_cnt_q == CNT_W'(i)) begin
        exp_digit_s = bus.pwd_in[(PWD_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end else begin
        exp_digit_s = exp_digit_s;
      end
    end
  end

  // Clear beats a simultaneous key, so a digit is accepted only without clear.
  assign accept_s      = (state_q == ST_ENTRY) && bus.key_valid && !bus.key_clear;
  assign accept_last_s = accept_s && (digit_cnt_q == CNT_W'(PWD_LEN - 1));
  assign last_fail_s   = (fail_cnt_q == FCNT_W'(MAX_FAIL - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY: begin
        if (accept_last_s) state_d = ST_CHECK;
        else               state_d = ST_ENTRY;
      end
      ST_CHECK: begin
        if (mismatch_q && last_fail_s) state_d = ST_LOCK;
        else                           state_d = ST_ENTRY;
      end
      ST_LOCK: begin
        if (lock_cnt_q == {LCNT_W{1'b0}}) state_d = ST_ENTRY;
        else                              state_d = ST_LOCK;
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Output/datapath next values; all of them are registered below.
  always_comb begin
    unlock_d    = 1'b0;
    fail_d      = 1'b0;
    locked_d    = locked_q;
    mismatch_d  = mismatch_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    case (state_q)
      ST_ENTRY: begin
        if (bus.key_clear) begin
          digit_cnt_d = {CNT_W{1'b0}};
          mismatch_d  = 1'b0;
        end else if (bus.key_valid) begin
          digit_cnt_d = digit_cnt_q + CNT_W'(1);
          mismatch_d  = mismatch_q | (bus.key_digit != exp_digit_s);
        end else begin
          digit_cnt_d = digit_cnt_q;
        end
      end
      ST_CHECK: begin
        digit_cnt_d = {CNT_W{1'b0}};
        mismatch_d  = 1'b0;
        if (!mismatch_q) begin
          unlock_d   = 1'b1;
          fail_cnt_d = {FCNT_W{1'b0}};
        end else if (last_fail_s) begin
          // Counter is loaded with N-1 so locked stays high N cycles.
          fail_d     = 1'b1;
          fail_cnt_d = FCNT_W'(MAX_FAIL);
          locked_d   = 1'b1;
          lock_cnt_d = LCNT_W'(LOCK_CYCLES - 1);
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_cnt_q + FCNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (lock_cnt_q == {LCNT_W{1'b0}}) begin
          locked_d   = 1'b0;
          fail_cnt_d = {FCNT_W{1'b0}};
        end else begin
          lock_cnt_d = lock_cnt_q - LCNT_W'(1);
        end
      end
      default: begin
        locked_d    = 1'b0;
        mismatch_d  = 1'b0;
        digit_cnt_d = {CNT_W{1'b0}};
        fail_cnt_d  = {FCNT_W{1'b0}};
        lock_cnt_d  = {LCNT_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      digit_cnt_q <= {CNT_W{1'b0}};
      fail_cnt_q  <= {FCNT_W{1'b0}};
      lock_cnt_q  <= {LCNT_W{1'b0}};
    end else begin
      unlock_q    <= unlock_d;
      fail_q      <= fail_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.fail      = fail_q;
  assign bus.locked    = locked_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
endmodule
